// File: rtl/uart_pkg.sv
// Shared types and width helpers for the UART transmit scheduler.
package uart_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StFire,
      StWait,
      StHold
   } state_e;

   // Index width for an n-entry vector; never narrower than one bit.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request after ptr_i, wrapping at N.
module rr_arbiter #(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = 2
) (
   input  logic [IW-1:0] ptr_i,
   input  logic [N-1:0]  req_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o
);

   always_comb begin
      int unsigned j;
      logic        found;
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      j     = 0;
      for (int unsigned off = 1; off <= N; off++) begin
         j = (32'(ptr_i) + off) % N;
         if (!found && (|(req_i & (N'(1) << j)))) begin
            found = 1'b1;
            gnt_o = N'(1) << j;
            idx_o = IW'(j);
         end
      end
   end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter between N packet requesters; round-robin, grant held per packet.
module uart_tx_sched
   import uart_pkg::*;
#(
   parameter int unsigned N         = 4,
   parameter int unsigned W         = 8,
   parameter int unsigned MaxBurst  = 16,
   parameter int unsigned HoldTicks = 1024
) (
   input  logic                  CLK,
   input  logic                  RSTN,
   input  logic [N-1:0]          REQ_VALID,
   input  logic [N*W-1:0]        REQ_DATA,
   input  logic [N-1:0]          REQ_LAST,
   output logic [N-1:0]          REQ_READY,
   output logic [W-1:0]          TX_IN,
   output logic                  TX_OE,
   input  logic                  TX_RDY,
   output logic [idx_w(N)-1:0]   GRANT,
   output logic                  BUSY
);

   localparam int unsigned IW = idx_w(N);
   localparam int unsigned CW = $clog2(MaxBurst + 1);
   localparam int unsigned HW = $clog2(HoldTicks + 1);

   state_e        state_q;
   logic [IW-1:0] grant_q;
   logic [IW-1:0] ptr_q;
   logic [CW-1:0] cnt_q;
   logic [HW-1:0] hold_q;
   logic          last_q;
   logic [W-1:0]  tx_in_q;
   logic          tx_oe_q;

   logic [N-1:0]  arb_gnt;
   logic [IW-1:0] arb_idx;
   logic [IW-1:0] acc_idx;
   logic [N-1:0]  own_mask;
   logic          accept;
   logic [W-1:0]  acc_data;
   logic          acc_last;

   rr_arbiter #(
      .N  (N),
      .IW (IW)
   ) u_arb (
      .ptr_i (ptr_q),
      .req_i (REQ_VALID),
      .gnt_o (arb_gnt),
      .idx_o (arb_idx)
   );

   assign own_mask = N'(1) << grant_q;

   // Only IDLE (fresh arbitration) and HOLD (owner continues its packet) may take a byte.
   always_comb begin
      REQ_READY = '0;
      acc_idx   = grant_q;
      unique case (state_q)
         StIdle: begin
            if (TX_RDY) begin
               REQ_READY = arb_gnt;
               acc_idx   = arb_idx;
            end
         end
         StHold:  REQ_READY = REQ_VALID & own_mask;
         default: ;
      endcase
   end

   assign accept   = |REQ_READY;
   assign acc_data = REQ_DATA[32'(acc_idx) * W +: W];
   assign acc_last = |(REQ_LAST & (N'(1) << acc_idx));

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q <= StIdle;
         grant_q <= '0;
         ptr_q   <= IW'(N - 1);
         cnt_q   <= '0;
         hold_q  <= '0;
         last_q  <= 1'b0;
         tx_in_q <= '0;
         tx_oe_q <= 1'b0;
      end else begin
         tx_oe_q <= 1'b0;
         if (accept) begin
            tx_in_q <= acc_data;
            tx_oe_q <= 1'b1;
            last_q  <= acc_last;
         end
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  grant_q <= arb_idx;
                  cnt_q   <= CW'(1);
                  state_q <= StFire;
               end
            end
            StFire: state_q <= StWait;
            StWait: begin
               if (TX_RDY) begin
                  if (last_q || (cnt_q == CW'(MaxBurst))) begin
                     ptr_q   <= grant_q;
                     cnt_q   <= '0;
                     state_q <= StIdle;
                  end else begin
                     hold_q  <= '0;
                     state_q <= StHold;
                  end
               end
            end
            StHold: begin
               if (accept) begin
                  cnt_q   <= cnt_q + 1'b1;
                  state_q <= StFire;
               end else begin
                  hold_q <= hold_q + 1'b1;
                  if (hold_q == HW'(HoldTicks - 1)) begin
                     ptr_q   <= grant_q;
                     cnt_q   <= '0;
                     state_q <= StIdle;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign TX_IN = tx_in_q;
   assign TX_OE = tx_oe_q;
   assign GRANT = grant_q;
   assign BUSY  = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: directed scenarios plus randomized packets against a behavioural model.
module tb_uart_tx_sched;

   localparam int unsigned N = 4;
   localparam int unsigned W = 8;
   localparam int unsigned MaxBurst = 4;
   localparam int unsigned HoldTicks = 8;
   localparam int Depth = 256;
   localparam int PFree = 0, PFire = 1, PWait = 2, PHold = 3;

   logic           CLK = 1'b0;
   logic           RSTN = 1'b0;
   logic [N-1:0]   REQ_VALID = '0;
   logic [N*W-1:0] REQ_DATA = '0;
   logic [N-1:0]   REQ_LAST = '0;
   logic [N-1:0]   REQ_READY;
   logic [W-1:0]   TX_IN;
   logic           TX_OE;
   logic           TX_RDY = 1'b1;
   logic [1:0]     GRANT;
   logic           BUSY;

   uart_tx_sched #(
      .N         (N),
      .W         (W),
      .MaxBurst  (MaxBurst),
      .HoldTicks (HoldTicks)
   ) dut (
      .CLK       (CLK),
      .RSTN      (RSTN),
      .REQ_VALID (REQ_VALID),
      .REQ_DATA  (REQ_DATA),
      .REQ_LAST  (REQ_LAST),
      .REQ_READY (REQ_READY),
      .TX_IN     (TX_IN),
      .TX_OE     (TX_OE),
      .TX_RDY    (TX_RDY),
      .GRANT     (GRANT),
      .BUSY      (BUSY)
   );

   always #5 CLK = ~CLK;

   // Transmitter model: no reset, busy for a random frame length after each load.
   int tx_cnt = 0;
   always @(posedge CLK) begin
      if (tx_cnt != 0) begin
         tx_cnt <= tx_cnt - 1;
         TX_RDY <= (tx_cnt == 1);
      end else if (TX_OE) begin
         tx_cnt <= int'($urandom_range(10, 3));
         TX_RDY <= 1'b0;
      end
   end

   int n_cmp = 0;
   int n_fail = 0;

   task automatic cmp(input string name, input int unsigned act, input int unsigned exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name, input int budget);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: timed out after %0d cycles", name, budget);
   endtask

   // Per-requester byte streams: {last, data}.
   logic [8:0] src_mem [N][Depth];
   int src_wr [N];
   int src_rd [N];
   int exp_rd [N];

   task automatic push(input int i, input logic [7:0] d, input bit last);
      src_mem[i][src_wr[i]] = {last, d};
      src_wr[i]++;
   endtask

   logic [N-1:0] rdy_smp = '0;
   bit           gaps = 1'b0;
   logic [N-1:0] gap_st = '0;

   // Source driver: pop on the accept seen before the edge, then present the next byte.
   initial forever begin
      @(posedge CLK);
      #1;
      for (int i = 0; i < int'(N); i++) begin
         if (rdy_smp[i]) src_rd[i]++;
         if (!gaps) gap_st[i] = 1'b0;
         else if ($urandom_range(3, 0) == 0) gap_st[i] = ~gap_st[i];
         if (src_rd[i] < src_wr[i] && !gap_st[i]) begin
            REQ_VALID[i]        = 1'b1;
            REQ_DATA[i*W +: W]  = src_mem[i][src_rd[i]][7:0];
            REQ_LAST[i]         = src_mem[i][src_rd[i]][8];
         end else begin
            REQ_VALID[i]        = 1'b0;
            REQ_DATA[i*W +: W]  = W'($urandom);
            REQ_LAST[i]         = 1'($urandom);
         end
      end
   end

   int log_g [1024];
   int log_b [1024];
   int log_n = 0;

   // Behavioural model: owner/phase bookkeeping straight from the scheduling rules.
   int         m_phase = PFree;
   int         m_ptr = N - 1;
   int         m_cnt = 0;
   int         m_hold = 0;
   int         m_grant = 0;
   bit         m_last = 1'b0;
   bit         m_oe = 1'b0;
   logic [7:0] m_in = '0;

   initial forever begin
      logic [N-1:0] e_rdy;
      int pick;
      int g;
      bit rel;
      @(negedge CLK);
      if (!RSTN) begin
         m_phase = PFree; m_ptr = N - 1; m_cnt = 0; m_hold = 0;
         m_grant = 0; m_last = 1'b0; m_oe = 1'b0; m_in = '0;
         rdy_smp = '0;
         cmp("rst_ready", REQ_READY, 0);
         cmp("rst_oe", TX_OE, 0);
         cmp("rst_in", TX_IN, 0);
         cmp("rst_grant", GRANT, 0);
         cmp("rst_busy", BUSY, 0);
      end else begin
         pick = -1;
         if (m_phase == PFree && TX_RDY) begin
            for (int k = 1; k <= int'(N); k++) begin
               if (pick < 0 && REQ_VALID[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
            end
         end else if (m_phase == PHold && REQ_VALID[m_grant]) begin
            pick = m_grant;
         end
         e_rdy = '0;
         if (pick >= 0) e_rdy[pick] = 1'b1;
         cmp("ready", REQ_READY, e_rdy);
         cmp("tx_oe", TX_OE, m_oe);
         cmp("tx_in", TX_IN, m_in);
         cmp("grant", GRANT, m_grant);
         cmp("busy", BUSY, m_phase != PFree);
         if (TX_OE) begin
            g = int'(GRANT);
            cmp("oe_while_tx_idle", TX_RDY, 1);
            if (exp_rd[g] >= src_wr[g]) timeout("stream_overrun", 0);
            else begin
               cmp("stream_byte", TX_IN, src_mem[g][exp_rd[g]][7:0]);
               exp_rd[g]++;
            end
            if (log_n < 1024) begin
               log_g[log_n] = g;
               log_b[log_n] = int'(TX_IN);
               log_n++;
            end
         end
         rdy_smp = REQ_READY;
         rel = 1'b0;
         if (m_phase == PFree) begin
            if (pick >= 0) begin m_grant = pick; m_cnt = 1; m_phase = PFire; end
         end else if (m_phase == PFire) begin
            m_phase = PWait;
         end else if (m_phase == PWait) begin
            if (TX_RDY) begin
               if (m_last || m_cnt == int'(MaxBurst)) rel = 1'b1;
               else begin m_phase = PHold; m_hold = 0; end
            end
         end else begin
            if (pick >= 0) begin m_cnt++; m_phase = PFire; end
            else begin
               m_hold++;
               if (m_hold == int'(HoldTicks)) rel = 1'b1;
            end
         end
         if (rel) begin m_ptr = m_grant; m_cnt = 0; m_phase = PFree; end
         m_oe = (pick >= 0);
         if (pick >= 0) begin
            m_in   = REQ_DATA[pick*W +: W];
            m_last = REQ_LAST[pick];
         end
      end
   end

   function automatic bit all_done();
      if (BUSY || !TX_RDY) return 1'b0;
      for (int i = 0; i < int'(N); i++)
         if (src_rd[i] != src_wr[i] || exp_rd[i] != src_wr[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic drain(input string name, input int budget);
      int c = 0;
      @(negedge CLK);
      while (!all_done() && c < budget) begin @(negedge CLK); c++; end
      if (!all_done()) timeout(name, budget);
   endtask

   task automatic wait_ready(input int i, input int budget);
      int c = 0;
      @(negedge CLK);
      while (!REQ_READY[i] && c < budget) begin @(negedge CLK); c++; end
      if (!REQ_READY[i]) timeout($sformatf("wait_ready%0d", i), budget);
   endtask

   task automatic expect_log(input int idx, input int g, input int b);
      if (idx >= log_n) timeout($sformatf("log%0d_missing", idx), 0);
      else begin
         cmp($sformatf("log%0d_grant", idx), log_g[idx], g);
         cmp($sformatf("log%0d_byte", idx), log_b[idx], b);
      end
   endtask

   task automatic pulse_reset();
      @(posedge CLK); #2 RSTN = 1'b0;
      @(posedge CLK); @(posedge CLK); #2 RSTN = 1'b1;
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base;
      int c;
      repeat (3) @(posedge CLK);
      #2 RSTN = 1'b1;

      // Single byte from requester 0.
      push(0, 8'h55, 1'b1);
      wait_ready(0, 50);
      cmp("s1_ready", REQ_READY, 4'b0001);
      cmp("s1_oe_pre", TX_OE, 0);
      @(negedge CLK);
      cmp("s1_oe", TX_OE, 1);
      cmp("s1_in", TX_IN, 8'h55);
      cmp("s1_grant", GRANT, 0);
      cmp("s1_busy", BUSY, 1);
      drain("s1_drain", 200);
      cmp("s1_busy_end", BUSY, 0);

      // Pointer now 0: requester 1 beats requester 0.
      base = log_n;
      push(0, 8'h60, 1'b1);
      push(1, 8'h61, 1'b1);
      drain("s1b_drain", 400);
      expect_log(base, 1, 8'h61);
      expect_log(base + 1, 0, 8'h60);

      // Round-robin from reset.
      pulse_reset();
      base = log_n;
      for (int i = 0; i < int'(N); i++) begin
         push(i, 8'h10 + 8'(i), 1'b1);
         push(i, 8'h20 + 8'(i), 1'b1);
      end
      drain("s2_drain", 1000);
      for (int k = 0; k < 8; k++)
         expect_log(base + k, k % 4, (k < 4 ? 8'h10 : 8'h20) + k % 4);

      // Burst cap: requester 0 streams 10 bytes without LAST, requester 3 has a packet.
      base = log_n;
      for (int k = 0; k < 10; k++) push(0, 8'hC0 + 8'(k), 1'b0);
      push(3, 8'hD0, 1'b0);
      push(3, 8'hD1, 1'b1);
      drain("s4_drain", 2000);
      for (int k = 0; k < 4; k++) expect_log(base + k, 0, 8'hC0 + k);
      expect_log(base + 4, 3, 8'hD0);
      expect_log(base + 5, 3, 8'hD1);
      for (int k = 4; k < 10; k++) expect_log(base + k + 2, 0, 8'hC0 + k);

      // Packet hold: requester 1's packet completes before requester 2.
      base = log_n;
      push(1, 8'hA1, 1'b0);
      push(1, 8'hA2, 1'b0);
      push(1, 8'hA3, 1'b1);
      push(2, 8'hB2, 1'b1);
      drain("s3_drain", 1000);
      expect_log(base, 1, 8'hA1);
      expect_log(base + 1, 1, 8'hA2);
      expect_log(base + 2, 1, 8'hA3);
      expect_log(base + 3, 2, 8'hB2);

      // Hold timeout: requester 2 stalls mid-packet, requester 0 waits then wins.
      base = log_n;
      push(2, 8'hE2, 1'b0);
      wait_ready(2, 50);
      push(0, 8'hF0, 1'b1);
      c = 0;
      while (TX_RDY && c < 20) begin @(negedge CLK); c++; end
      c = 0;
      while (!TX_RDY && c < 50) begin @(negedge CLK); c++; end
      if (!TX_RDY) timeout("s5_frame", 50);
      c = 0;
      while (!REQ_READY[0] && c < 40) begin @(negedge CLK); c++; end
      cmp("s5_hold_cycles", c, HoldTicks + 1);
      drain("s5_drain", 400);
      expect_log(base, 2, 8'hE2);
      expect_log(base + 1, 0, 8'hF0);

      // Reset while the transmitter is mid-frame.
      base = log_n;
      push(1, 8'h71, 1'b0);
      push(1, 8'h72, 1'b0);
      push(1, 8'h73, 1'b1);
      c = 0;
      @(negedge CLK);
      while (!(BUSY && !TX_RDY) && c < 100) begin @(negedge CLK); c++; end
      if (!(BUSY && !TX_RDY)) timeout("s6_wait", 100);
      @(posedge CLK);
      #2 RSTN = 1'b0;
      #1;
      cmp("s6_rst_oe", TX_OE, 0);
      cmp("s6_rst_busy", BUSY, 0);
      cmp("s6_rst_grant", GRANT, 0);
      cmp("s6_rst_in", TX_IN, 0);
      cmp("s6_rst_ready", REQ_READY, 0);
      @(posedge CLK);
      #2 RSTN = 1'b1;
      c = 0;
      @(negedge CLK);
      while (!TX_RDY && c < 50) begin
         cmp("s6_quiet_oe", TX_OE, 0);
         @(negedge CLK);
         c++;
      end
      drain("s6_drain", 600);
      expect_log(base, 1, 8'h71);
      expect_log(base + 1, 1, 8'h72);
      expect_log(base + 2, 1, 8'h73);

      // Randomized packets with VALID gaps on every requester.
      gaps = 1'b1;
      for (int i = 0; i < int'(N); i++) begin
         for (int p = 0; p < 8; p++) begin
            int len;
            len = int'($urandom_range(6, 1));
            for (int b = 0; b < len; b++) push(i, 8'($urandom), b == len - 1);
         end
      end
      drain("rand_drain", 30000);
      gaps = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
